vga_capture: RTL
================

// Module: vga_capture
// PURPOSE
//  Receive-side VGA monitor: samples hsync/vsync/valid/RGB from a VGA source (e.g. the 640x480
//  char-mode timing generator), locks onto its timing, and emits a pixel write stream
//  (x, y, 24-bit colour) for a framebuffer/checker. Measures line/frame geometry and flags
//  timing errors. Used in the NPC display path for self-check and capture in simulation.
// PARAMETERS
//  H_TOTAL   800  expected clocks per line (hsync fall to hsync fall)
//  V_TOTAL   525  expected lines per frame (vsync fall to vsync fall)
//  H_ACTIVE  640  expected valid pixels per active line
//  V_ACTIVE  480  expected active lines (lines with >=1 valid pixel) per frame
// PORTS
//  pclk         in   1   pixel clock (25 MHz)
//  reset        in   1   synchronous, active-high
//  hsync        in   1   line sync, active low; line starts on its falling edge
//  vsync        in   1   frame sync, active low; frame starts on its falling edge
//  valid        in   1   active-video qualifier
//  vga_r/g/b    in   8   colour, each 8 bit
//  pix_we       out  1   pixel write strobe (one per captured pixel)
//  pix_x        out  10  pixel column in active line, 0..H_ACTIVE-1
//  pix_y        out  10  active line index, 0..V_ACTIVE-1
//  pix_data     out  24  {r,g,b}
//  frame_done   out  1   1-cycle pulse: a LOCK-state frame completed without error
//  locked       out  1   high in S_LOCK
//  err_hline    out  1   1-cycle pulse: line period/pixel-count error
//  err_vframe   out  1   1-cycle pulse: frame line-count/active-line error
//  line_len     out  10  last measured line period in clocks
//  frame_lines  out  10  last measured lines per frame
// BEHAVIOUR
//  - Reset: all outputs 0, state S_IDLE, all counters 0. Reset mid-frame discards capture.
//  - Input stage: hsync/vsync/valid/RGB registered once (s_*) plus one delayed copy for edges.
//    Pixel sampled at edge k appears on pix_* after edge k+1 (latency 1 clock after sampling).
//  - hcnt (10b): +1 per clock, cleared on hsync fall; on fall line_len <= hcnt+1.
//    hcnt saturates at 1023 -> err_hline pulse, state -> S_IDLE (sync lost).
//  - xcnt: counts valid pixels in line, cleared on hsync fall; pix_x = xcnt before increment.
//    Pixel with xcnt >= H_ACTIVE: no pix_we, line marked bad.
//  - vcnt: lines since vsync fall (+1 per hsync fall); on vsync fall frame_lines <= vcnt.
//  - pix_y: +1 on hsync fall if finished line had >=1 valid pixel; cleared on vsync fall.
//  - Line check at hsync fall: error if line_len != H_TOTAL, or xcnt not in {0, H_ACTIVE}.
//    Outside S_IDLE an error pulses err_hline and sets sticky frame_bad.
//  - Frame check at vsync fall: error if vcnt != V_TOTAL, active lines != V_ACTIVE, or frame_bad.
//  - FSM: S_IDLE --vsync fall--> S_TRAIN (counters cleared).
//    S_TRAIN --vsync fall, frame ok--> S_LOCK; frame bad -> stay S_TRAIN (no err pulse).
//    S_LOCK --vsync fall, ok--> S_LOCK + frame_done; bad -> S_TRAIN + err_vframe pulse.
//    frame_bad cleared at every vsync fall.
//  - pix_we only in S_LOCK with s_valid=1 and xcnt < H_ACTIVE; pix_y >= V_ACTIVE also blocks.
//  - hsync and vsync fall same cycle: line check then frame check both evaluated; vsync fall
//    counts the closing line (vcnt+1) before compare.
//  - Widths: all counters 10b unsigned; no wrap other than stated saturation.
// TESTING
//  1 Clean 800x525 timing (hsync low 96, vsync low 2 lines, valid cols 145-784, rows 36-515)
//    -> locked rises at 2nd vsync fall after reset; line_len=800, frame_lines=525, no errors.
//  2 Locked, gradient RGB={x[7:0],y[7:0],8'h5a} -> 307200 pix_we per frame, pix_x 0..639,
//    pix_y 0..479, data matches, frame_done exactly once per frame.
//  3 Locked, one line stretched to 801 clocks -> err_hline 1 pulse; at next vsync fall
//    err_vframe pulse, locked=0; relock after one clean frame.
//  4 Locked, hsync held high 1100 clocks -> err_hline at hcnt=1023, state S_IDLE, locked=0.
//  5 One line with 641 valid pixels -> 640 pix_we on that line, err_hline, frame rejected.
//  6 Reset asserted mid-frame for 3 clocks -> all outputs 0; relock needs IDLE->TRAIN->LOCK.

Source files
------------

// File: rtl/vga_capture.sv
// vga_capture: locks onto VGA sync timing, emits a pixel write stream and flags line/frame timing errors.
module vga_capture #(
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        valid,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    output logic        pix_we,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [23:0] pix_data,
    output logic        frame_done,
    output logic        locked,
    output logic        err_hline,
    output logic        err_vframe,
    output logic [9:0]  line_len,
    output logic [9:0]  frame_lines
);
    localparam logic [9:0] HT  = 10'(H_TOTAL);
    localparam logic [9:0] VT  = 10'(V_TOTAL);
    localparam logic [9:0] HA  = 10'(H_ACTIVE);
    localparam logic [9:0] VA  = 10'(V_ACTIVE);
    localparam logic [9:0] MAX = 10'h3ff;
    typedef enum logic [1:0] {S_IDLE, S_TRAIN, S_LOCK} state_t;
    state_t state, state_nxt;
    logic s_hsync, s_vsync, s_valid, d_hsync, d_vsync;
    logic [23:0] s_rgb;
    logic [9:0] hcnt, xcnt, vcnt, ycnt;
    logic frame_bad, h_fall, v_fall, line_err, sat, frame_err, we_nxt;
    logic [9:0] x_cur, y_cur, y_tot, v_tot;
    assign locked = state == S_LOCK;
    // A pixel arriving on the same cycle as a sync fall belongs to the new line/frame.
    always_comb begin
        h_fall    = d_hsync & ~s_hsync;
        v_fall    = d_vsync & ~s_vsync;
        x_cur     = h_fall ? '0 : xcnt;
        y_tot     = ycnt + {9'b0, h_fall && xcnt != '0 && ycnt != MAX};
        v_tot     = vcnt + {9'b0, h_fall && vcnt != MAX};
        y_cur     = v_fall ? '0 : y_tot;
        line_err  = state != S_IDLE && h_fall && (hcnt + 10'd1 != HT || (xcnt != '0 && xcnt != HA));
        sat       = state != S_IDLE && !h_fall && hcnt == MAX - 10'd1;
        frame_err = v_tot != VT || y_tot != VA || frame_bad || line_err;
        we_nxt    = state == S_LOCK && s_valid && x_cur < HA && y_cur < VA;
        state_nxt = state;
        if (sat)
            state_nxt = S_IDLE;
        else if (v_fall)
            state_nxt = (state == S_IDLE || frame_err) ? S_TRAIN : S_LOCK;
    end
    always_ff @(posedge pclk)
        state <= reset ? S_IDLE : state_nxt;
    always_ff @(posedge pclk) begin
        if (reset) begin
            {s_hsync, s_vsync, s_valid, d_hsync, d_vsync, s_rgb} <= '0;
            {hcnt, xcnt, vcnt, ycnt, frame_bad} <= '0;
            {pix_we, pix_x, pix_y, pix_data} <= '0;
            {frame_done, err_hline, err_vframe, line_len, frame_lines} <= '0;
        end else begin
            {s_hsync, s_vsync, s_valid, s_rgb} <= {hsync, vsync, valid, vga_r, vga_g, vga_b};
            {d_hsync, d_vsync} <= {s_hsync, s_vsync};
            hcnt        <= h_fall ? '0 : (hcnt == MAX ? hcnt : hcnt + 10'd1);
            xcnt        <= x_cur + {9'b0, s_valid && x_cur != MAX};
            vcnt        <= v_fall ? '0 : v_tot;
            ycnt        <= y_cur;
            frame_bad   <= !v_fall && (frame_bad || line_err);
            pix_we      <= we_nxt;
            pix_x       <= x_cur;
            pix_y       <= y_cur;
            pix_data    <= s_rgb;
            frame_done  <= v_fall && !sat && state == S_LOCK && !frame_err;
            err_vframe  <= v_fall && !sat && state == S_LOCK && frame_err;
            err_hline   <= line_err || sat;
            line_len    <= h_fall ? hcnt + 10'd1 : line_len;
            frame_lines <= v_fall ? v_tot : frame_lines;
        end
    end
endmodule
